// File: rtl/rca_add_sequencer.sv
// Multi-precision add sequencer: round-robin arbitration between two requesters,
// then one OP_WIDTH-bit add streamed LSB-first through a shared registered-input adder slice.

module rca_slice #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_cin,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic                  o_cout
);

    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_cin;
    logic [DATA_WIDTH:0]   w_carry;

    // Operand registers: the sum seen by the sequencer lags its inputs by one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= 1'b0;
        end else begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_cin <= i_cin;
        end
    end

    assign w_carry[0] = r_cin;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fa
        assign o_sum[i]       = r_a[i] ^ r_b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (r_a[i] & r_b[i]) | (r_a[i] & w_carry[i]) | (r_b[i] & w_carry[i]);
    end

    assign o_cout = w_carry[DATA_WIDTH];

endmodule

module rca_add_sequencer #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NSLICES    = 4,
    localparam int OP_WIDTH   = DATA_WIDTH * NSLICES
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic [OP_WIDTH-1:0]   i_a0,
    input  logic [OP_WIDTH-1:0]   i_b0,
    input  logic                  i_cin0,
    input  logic [OP_WIDTH-1:0]   i_a1,
    input  logic [OP_WIDTH-1:0]   i_b1,
    input  logic                  i_cin1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic                  o_rsp_id,
    output logic [OP_WIDTH-1:0]   o_rsp_sum,
    output logic                  o_rsp_cout,
    output logic                  o_busy,
    output logic [DATA_WIDTH-1:0] o_add_a,
    output logic [DATA_WIDTH-1:0] o_add_b,
    output logic                  o_add_cin,
    input  logic [DATA_WIDTH-1:0] i_add_sum,
    input  logic                  i_add_cout
);

    localparam int             IW       = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(NSLICES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         w_prev_idx;
    logic [OP_WIDTH-1:0]   r_a;
    logic [OP_WIDTH-1:0]   r_b;
    logic                  r_cin;
    logic                  r_id;
    logic                  r_ptr;
    logic [OP_WIDTH-1:0]   r_sum;
    logic                  r_cout;
    logic                  r_valid;
    logic                  r_busy;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_a_slice;
    logic [DATA_WIDTH-1:0] w_b_slice;

    // Round-robin arbitration; r_ptr names the requester served last.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if ((r_state == S_IDLE) && !i_rst) begin
            if (i_req0 && i_req1) begin
                if (r_ptr) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else if (i_req0) begin
                w_gnt0 = 1'b1;
            end else if (i_req1) begin
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign w_accept   = w_gnt0 | w_gnt1;
    assign w_prev_idx = r_idx - IW'(1);
    assign w_a_slice  = r_a[int'(r_idx) * DATA_WIDTH +: DATA_WIDTH];
    assign w_b_slice  = r_b[int'(r_idx) * DATA_WIDTH +: DATA_WIDTH];

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and slice drive; the carry chains combinationally from the slice's lagged cout.
    always_comb begin
        w_state_nxt = r_state;
        o_add_a     = '0;
        o_add_b     = '0;
        o_add_cin   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                o_add_a = w_a_slice;
                o_add_b = w_b_slice;
                if (r_idx == '0) begin
                    o_add_cin = r_cin;
                end else begin
                    o_add_cin = i_add_cout;
                end
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, slice index and result assembly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_cin  <= 1'b0;
            r_id   <= 1'b0;
            r_ptr  <= 1'b1;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a    <= w_gnt1 ? i_a1 : i_a0;
                        r_b    <= w_gnt1 ? i_b1 : i_b0;
                        r_cin  <= w_gnt1 ? i_cin1 : i_cin0;
                        r_id   <= w_gnt1;
                        r_ptr  <= w_gnt1;
                        r_sum  <= '0;
                        r_cout <= 1'b0;
                        r_idx  <= '0;
                    end
                end
                S_ISSUE: begin
                    if (r_idx != '0) begin
                        r_sum[int'(w_prev_idx) * DATA_WIDTH +: DATA_WIDTH] <= i_add_sum;
                    end
                    if (r_idx != LAST_IDX) begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DRAIN: begin
                    r_sum[(NSLICES - 1) * DATA_WIDTH +: DATA_WIDTH] <= i_add_sum;
                    r_cout <= i_add_cout;
                end
                S_DONE: begin
                    r_idx <= r_idx;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    // Status flags registered from the next state so they align with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= (w_state_nxt == S_DONE);
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign o_gnt0      = w_gnt0;
    assign o_gnt1      = w_gnt1;
    assign o_rsp_valid = r_valid;
    assign o_rsp_id    = r_id;
    assign o_rsp_sum   = r_sum;
    assign o_rsp_cout  = r_cout;
    assign o_busy      = r_busy;

endmodule
